// File: rtl/imm_ext_pkg.sv
// Shared mode encodings for the immediate extender.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO   = 2'b00,
        MODE_SIGN   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } imm_mode_t;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Operand/result handshake bundle between decode and the immediate extender.
interface imm_ext_pipe_if #(
    parameter int N = 16,
    parameter int M = 32
);
    import imm_ext_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  immediateIN;
    imm_mode_t     mode;
    logic          out_valid;
    logic          out_ready;
    logic [M-1:0]  immediateOUT;
    imm_mode_t     out_mode;

    modport slave (
        input  in_valid, immediateIN, mode, out_ready,
        output in_ready, out_valid, immediateOUT, out_mode
    );

    modport master (
        output in_valid, immediateIN, mode, out_ready,
        input  in_ready, out_valid, immediateOUT, out_mode
    );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational zero/sign/upper/branch immediate extension.
module imm_ext_core import imm_ext_pkg::*; #(
    parameter int N       = 16,
    parameter int M       = 32,
    parameter int SHIFT_B = 2
) (
    input  logic [N-1:0] imm,
    input  imm_mode_t    mode,
    output logic [M-1:0] ext
);

    if (N < 2 || M <= N || M < N + SHIFT_B) begin : g_bad_params
        $error("imm_ext_core: need N >= 2, M > N and M >= N + SHIFT_B");
    end

    logic [M-1:0] sext;

    always_comb begin
        sext = {{(M-N){imm[N-1]}}, imm};
        ext  = '0;
        case (mode)
            MODE_ZERO:   ext = {{(M-N){1'b0}}, imm};
            MODE_SIGN:   ext = sext;
            // {imm, zeros} is exactly M bits wide, so bits above M never exist.
            MODE_UPPER:  ext = {imm, {(M-N){1'b0}}};
            MODE_BRANCH: ext = sext << SHIFT_B;
            default:     ext = '0;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage valid/ready wrapper around imm_ext_core with a consumed-result counter.
module imm_ext_pipe import imm_ext_pkg::*; #(
    parameter int N       = 16,
    parameter int M       = 32,
    parameter int SHIFT_B = 2,
    parameter int CW      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    imm_ext_pipe_if.slave   bus,
    output logic [CW-1:0]   done_count
);

    if (N < 2 || M <= N || M < N + SHIFT_B) begin : g_bad_params
        $error("imm_ext_pipe: need N >= 2, M > N and M >= N + SHIFT_B");
    end

    logic          s1_valid_q, s1_valid_d;
    logic [N-1:0]  s1_imm_q,   s1_imm_d;
    imm_mode_t     s1_mode_q,  s1_mode_d;
    logic          s2_valid_q, s2_valid_d;
    logic [M-1:0]  s2_ext_q,   s2_ext_d;
    imm_mode_t     s2_mode_q,  s2_mode_d;
    logic [CW-1:0] count_q,    count_d;

    logic          adv1, adv2, in_ready, accept, fire;
    logic [M-1:0]  ext;

    imm_ext_core #(.N(N), .M(M), .SHIFT_B(SHIFT_B)) u_core (
        .imm  (s1_imm_q),
        .mode (s1_mode_q),
        .ext  (ext)
    );

    always_comb begin
        adv2     = !s2_valid_q | bus.out_ready;
        adv1     = !s1_valid_q | adv2;
        in_ready = adv1 & !flush & rst_n;
        accept   = bus.in_valid & in_ready;
        fire     = s2_valid_q & bus.out_ready;

        s1_valid_d = s1_valid_q;
        s1_imm_d   = s1_imm_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        s2_ext_d   = s2_ext_q;
        s2_mode_d  = s2_mode_q;
        // A handshake on a flush edge still completes, so counting ignores flush.
        count_d    = count_q + CW'(fire);

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (adv2) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_ext_d  = ext;
                    s2_mode_d = s1_mode_q;
                end
            end
            if (adv1) begin
                s1_valid_d = accept;
                if (accept) begin
                    s1_imm_d  = bus.immediateIN;
                    s1_mode_d = bus.mode;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_imm_q   <= '0;
            s1_mode_q  <= MODE_ZERO;
            s2_valid_q <= 1'b0;
            s2_ext_q   <= '0;
            s2_mode_q  <= MODE_ZERO;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_imm_q   <= s1_imm_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_ext_q   <= s2_ext_d;
            s2_mode_q  <= s2_mode_d;
            count_q    <= count_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = s2_valid_q;
    assign bus.immediateOUT = s2_ext_q;
    assign bus.out_mode     = s2_mode_q;
    assign done_count       = count_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe; a CW=2 twin shares the stimulus to exercise counter wrap.
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [15:0] dc;
    logic [1:0]  dcw;
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] held;
    logic [31:0] got_q[$];
    imm_mode_t   got_m[$];

    imm_ext_pipe_if #(.N(16), .M(32)) bus   ();
    imm_ext_pipe_if #(.N(16), .M(32)) bus_w ();

    assign bus_w.in_valid    = bus.in_valid;
    assign bus_w.immediateIN = bus.immediateIN;
    assign bus_w.mode        = bus.mode;
    assign bus_w.out_ready   = bus.out_ready;

    imm_ext_pipe #(.N(16), .M(32), .SHIFT_B(2), .CW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus),
        .done_count (dc)
    );

    imm_ext_pipe #(.N(16), .M(32), .SHIFT_B(2), .CW(2)) dut_w (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus_w),
        .done_count (dcw)
    );

    always #5 clk = ~clk;

    // Record every result that is consumed on the following rising edge.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.immediateOUT);
            got_m.push_back(bus.out_mode);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
    task automatic send(input imm_mode_t m, input logic [15:0] v);
        int n = 0;
        bus.in_valid    = 1'b1;
        bus.immediateIN = v;
        bus.mode        = m;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.immediateIN = '0;
        bus.mode        = MODE_ZERO;
        bus.out_ready   = 1'b1;
        #12;
        chk("rst_in_ready",  bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_imm_out",   bus.immediateOUT, 0);
        chk("rst_out_mode",  bus.out_mode, 0);
        chk("rst_dc",        dc, 0);
        rst_n = 1'b1;
        step();

        // Four modes, with first-result latency.
        got_q.delete(); got_m.delete();
        send(MODE_ZERO, 16'h000A);
        chk("lat_s1_only", bus.out_valid, 0);
        step();
        chk("lat_out_valid", bus.out_valid, 1);
        chk("lat_imm", bus.immediateOUT, 32'h0000000A);
        send(MODE_SIGN,   16'h800A);
        send(MODE_UPPER,  16'h1E1F);
        send(MODE_BRANCH, 16'hFE1F);
        repeat (4) step();
        chk("m_cnt", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("m_zero",   got_q[0], 32'h0000000A);
            chk("m_sign",   got_q[1], 32'hFFFF800A);
            chk("m_upper",  got_q[2], 32'h1E1F0000);
            chk("m_branch", got_q[3], 32'hFFFFF87C);
            chk("m_mode3",  got_m[3], 2'b11);
        end
        chk("dc_4", dc, 4);
        chk("dcw_wrap0", dcw, 0);
        send(MODE_ZERO, 16'h0005);
        repeat (3) step();
        chk("dc_5", dc, 5);
        chk("dcw_wrap1", dcw, 1);

        // Stream of 8 with a 3-cycle downstream stall.
        got_q.delete(); got_m.delete();
        fork
            for (int i = 1; i <= 8; i++) send(MODE_SIGN, 16'(i));
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                held = bus.immediateOUT;
                for (int k = 0; k < 3; k++) begin
                    step();
                    chk("stall_hold", bus.immediateOUT, held);
                end
                chk("stall_in_ready", bus.in_ready, 0);
                chk("stall_out_valid", bus.out_valid, 1);
                bus.out_ready = 1'b1;
            end
        join
        repeat (4) step();
        chk("s_cnt", got_q.size(), 8);
        if (got_q.size() == 8)
            for (int i = 0; i < 8; i++) chk("s_order", got_q[i], 32'(i + 1));
        chk("dc_13", dc, 13);
        chk("dcw_13", dcw, 1);

        // Sign-boundary cases.
        got_q.delete(); got_m.delete();
        send(MODE_BRANCH, 16'h7FFF);
        send(MODE_ZERO,   16'hFFFF);
        send(MODE_SIGN,   16'h7FFF);
        repeat (4) step();
        chk("b_cnt", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("b_branch_pos", got_q[0], 32'h0001FFFC);
            chk("b_zero_ff",    got_q[1], 32'h0000FFFF);
            chk("b_sign_pos",   got_q[2], 32'h00007FFF);
        end
        chk("dc_16", dc, 16);

        // Flush with two in flight: the stage-2 result completes on the flush edge, stage 1 is dropped.
        send(MODE_ZERO, 16'h0011);
        send(MODE_ZERO, 16'h0022);
        flush           = 1'b1;
        bus.in_valid    = 1'b1;
        bus.immediateIN = 16'h0BAD;
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_dc", dc, 17);
        step();
        chk("flush_no_accept", bus.out_valid, 0);
        got_q.delete(); got_m.delete();
        send(MODE_ZERO, 16'h0003);
        repeat (3) step();
        chk("f_cnt", got_q.size(), 1);
        if (got_q.size() == 1) chk("f_after", got_q[0], 32'h00000003);
        chk("dc_18", dc, 18);

        // Asynchronous reset with a full pipeline.
        bus.out_ready = 1'b0;
        send(MODE_SIGN, 16'h1111);
        send(MODE_SIGN, 16'h2222);
        chk("full_out_valid", bus.out_valid, 1);
        chk("full_in_ready", bus.in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_dc", dc, 0);
        chk("arst_dcw", dcw, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("arst_lost", bus.out_valid, 0);
        got_q.delete(); got_m.delete();
        send(MODE_SIGN, 16'h8000);
        repeat (3) step();
        chk("r_cnt", got_q.size(), 1);
        if (got_q.size() == 1) chk("r_after", got_q[0], 32'hFFFF8000);
        chk("dc_1", dc, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
